// File: rtl/dbus_arbiter.sv
// Multi-master DBus arbiter and multiplexer: registered one-hot grant with
// round-robin or fixed priority, bounded bus locking and stall-frozen ownership.
module dbus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int RR_MODE     = 1,
  parameter int MAX_LOCK    = 16
) (
  input  logic                          i_Clk,
  input  logic                          i_nRst,
  input  logic [NUM_MASTERS-1:0]        i_Req,
  input  logic [NUM_MASTERS-1:0]        i_Lock,
  output logic [NUM_MASTERS-1:0]        o_Gnt,
  input  logic [NUM_MASTERS*ADDR_W-1:0] i_M_Address,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] i_M_ByteEn,
  input  logic [NUM_MASTERS-1:0]        i_M_Read,
  input  logic [NUM_MASTERS-1:0]        i_M_Write,
  input  logic [NUM_MASTERS*DATA_W-1:0] i_M_WriteData,
  output logic [DATA_W-1:0]             o_M_ReadData,
  output logic [NUM_MASTERS-1:0]        o_M_WaitRequest,
  output logic [ADDR_W-1:0]             o_S_Address,
  output logic [DATA_W/8-1:0]           o_S_ByteEn,
  output logic                          o_S_Read,
  output logic                          o_S_Write,
  output logic [DATA_W-1:0]             o_S_WriteData,
  input  logic [DATA_W-1:0]             i_S_ReadData,
  input  logic                          i_S_WaitRequest
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = (MAX_LOCK > 0) ? $clog2(MAX_LOCK + 1) : 1;
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [CNT_W-1:0]       lock_cnt_q, lock_cnt_d;

  logic                   others_req;
  logic                   owner_lock;
  logic                   hold_wait;
  logic                   keep_lock;
  logic [NUM_MASTERS-1:0] elig;
  logic                   found;
  logic [IDX_W-1:0]       win_idx;

  always_comb begin
    others_req = |(i_Req & ~gnt_q);
    owner_lock = |(gnt_q & i_Lock);
    hold_wait  = (|gnt_q) && i_S_WaitRequest;
    keep_lock  = (|(gnt_q & i_Req & i_Lock)) &&
                 (!others_req || (MAX_LOCK == 0) || (lock_cnt_q < LOCK_MAX));
    // The current owner only competes when it is the sole requester.
    elig       = others_req ? (i_Req & ~gnt_q) : i_Req;

    found   = 1'b0;
    win_idx = '0;
    if (RR_MODE != 0) begin
      for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
        int unsigned idx;
        idx = int'(last_q) + k;
        if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
        if (!found && elig[idx]) begin
          found   = 1'b1;
          win_idx = IDX_W'(idx);
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (!found && elig[i]) begin
          found   = 1'b1;
          win_idx = IDX_W'(i);
        end
      end
    end

    gnt_d  = gnt_q;
    last_d = last_q;
    if (!hold_wait && !keep_lock) begin
      gnt_d          = '0;
      gnt_d[win_idx] = found;
      if (found) last_d = win_idx;
    end

    lock_cnt_d = lock_cnt_q;
    if ((gnt_d != gnt_q) || !owner_lock) begin
      lock_cnt_d = '0;
    end else if (!hold_wait && keep_lock && others_req &&
                 (MAX_LOCK != 0) && (lock_cnt_q != LOCK_MAX)) begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      gnt_q      <= '0;
      last_q     <= IDX_W'(NUM_MASTERS - 1);
      lock_cnt_q <= '0;
    end else begin
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_comb begin
    o_Gnt         = gnt_q;
    o_S_Address   = '0;
    o_S_ByteEn    = '0;
    o_S_WriteData = '0;
    o_S_Read      = |(gnt_q & i_M_Read);
    o_S_Write     = |(gnt_q & i_M_Write);
    o_M_ReadData  = i_S_ReadData;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_q[i]) begin
        o_S_Address   = o_S_Address   | i_M_Address[i*ADDR_W +: ADDR_W];
        o_S_ByteEn    = o_S_ByteEn    | i_M_ByteEn[i*BE_W +: BE_W];
        o_S_WriteData = o_S_WriteData | i_M_WriteData[i*DATA_W +: DATA_W];
      end
      o_M_WaitRequest[i] = gnt_q[i] ? i_S_WaitRequest : (i_M_Read[i] | i_M_Write[i]);
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: a 4-master round-robin instance with a lock
// bound of 4 and a 3-master fixed-priority instance with unlimited locking.
module tb_dbus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Instance A: N=4, round-robin, MAX_LOCK=4
  logic [3:0]  a_req, a_lock, a_read, a_write, a_gnt, a_mwait;
  logic [31:0] a_addr;
  logic [7:0]  a_be;
  logic [63:0] a_wd;
  logic [15:0] a_mrd, a_srd, a_swd;
  logic [7:0]  a_saddr;
  logic [1:0]  a_sbe;
  logic        a_sread, a_swrite, a_swait;

  dbus_arbiter #(.NUM_MASTERS(4), .ADDR_W(8), .DATA_W(16), .RR_MODE(1), .MAX_LOCK(4)) dut_a (
    .i_Clk(clk), .i_nRst(rst_n), .i_Req(a_req), .i_Lock(a_lock), .o_Gnt(a_gnt),
    .i_M_Address(a_addr), .i_M_ByteEn(a_be), .i_M_Read(a_read), .i_M_Write(a_write),
    .i_M_WriteData(a_wd), .o_M_ReadData(a_mrd), .o_M_WaitRequest(a_mwait),
    .o_S_Address(a_saddr), .o_S_ByteEn(a_sbe), .o_S_Read(a_sread), .o_S_Write(a_swrite),
    .o_S_WriteData(a_swd), .i_S_ReadData(a_srd), .i_S_WaitRequest(a_swait)
  );

  // Instance B: N=3, fixed priority, unlimited lock
  logic [2:0]  b_req, b_lock, b_read, b_write, b_gnt, b_mwait;
  logic [23:0] b_addr;
  logic [5:0]  b_be;
  logic [47:0] b_wd;
  logic [15:0] b_mrd, b_srd, b_swd;
  logic [7:0]  b_saddr;
  logic [1:0]  b_sbe;
  logic        b_sread, b_swrite, b_swait;

  dbus_arbiter #(.NUM_MASTERS(3), .ADDR_W(8), .DATA_W(16), .RR_MODE(0), .MAX_LOCK(0)) dut_b (
    .i_Clk(clk), .i_nRst(rst_n), .i_Req(b_req), .i_Lock(b_lock), .o_Gnt(b_gnt),
    .i_M_Address(b_addr), .i_M_ByteEn(b_be), .i_M_Read(b_read), .i_M_Write(b_write),
    .i_M_WriteData(b_wd), .o_M_ReadData(b_mrd), .o_M_WaitRequest(b_mwait),
    .o_S_Address(b_saddr), .o_S_ByteEn(b_sbe), .o_S_Read(b_sread), .o_S_Write(b_swrite),
    .o_S_WriteData(b_swd), .i_S_ReadData(b_srd), .i_S_WaitRequest(b_swait)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    a_req   = 4'hF; a_lock = 4'h0; a_read = 4'hF; a_write = 4'h0;
    a_addr  = {8'h44, 8'h33, 8'h22, 8'h11};
    a_be    = {2'b11, 2'b10, 2'b01, 2'b11};
    a_wd    = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    a_srd   = 16'hBEEF; a_swait = 1'b0;
    b_req   = 3'b000; b_lock = 3'b000; b_read = 3'b000; b_write = 3'b000;
    b_addr  = {8'hC2, 8'hC1, 8'hC0};
    b_be    = {2'b11, 2'b10, 2'b01};
    b_wd    = {16'hE002, 16'hE001, 16'hE000};
    b_srd   = 16'h0000; b_swait = 1'b0;

    // Reset state with all masters requesting
    #1;
    chk("rst_gnt", a_gnt, 4'b0000);
    chk("rst_sread", a_sread, 1'b0);
    chk("rst_swrite", a_swrite, 1'b0);
    chk("rst_saddr", a_saddr, 8'h00);
    chk("rst_rdata", a_mrd, 16'hBEEF);
    chk("rst_mwait", a_mwait, 4'b1111);
    step();
    chk("rst_hold_gnt", a_gnt, 4'b0000);
    rst_n = 1'b1;

    // Round-robin rotation
    step();
    chk("rr_gnt0", a_gnt, 4'b0001);
    chk("rr_saddr0", a_saddr, 8'h11);
    chk("rr_sread0", a_sread, 1'b1);
    chk("rr_mwait0", a_mwait, 4'b1110);
    step(); chk("rr_gnt1", a_gnt, 4'b0010);
    chk("rr_saddr1", a_saddr, 8'h22);
    chk("rr_sbe1", a_sbe, 2'b01);
    step(); chk("rr_gnt2", a_gnt, 4'b0100);
    step(); chk("rr_gnt3", a_gnt, 4'b1000);
    step(); chk("rr_gnt4", a_gnt, 4'b0001);
    step(); chk("rr_gnt5", a_gnt, 4'b0010);

    // Wait hold: master 1 drops request during a 3-cycle stall
    a_swait = 1'b1; a_req = 4'b0001;
    #1;
    chk("wait_mwait", a_mwait, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_hold_gnt", a_gnt, 4'b0010);
    end
    a_swait = 1'b0;
    step();
    chk("wait_release_gnt", a_gnt, 4'b0001);

    // Lock bound: master 0 locked with master 1 requesting
    a_req = 4'b0011; a_lock = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("lock_keep_gnt", a_gnt, 4'b0001);
    end
    step();
    chk("lock_rotate_gnt", a_gnt, 4'b0010);

    // Lock with no competitor holds indefinitely
    a_req = 4'b0001; a_write = 4'b0001;
    step();
    chk("lock_regain_gnt", a_gnt, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("lock_sole_gnt", a_gnt, 4'b0001);
    end
    chk("wr_swrite", a_swrite, 1'b1);
    chk("wr_swdata", a_swd, 16'hD000);
    chk("wr_sbe", a_sbe, 2'b11);

    // Asynchronous reset in the middle of a granted write
    #2 rst_n = 1'b0;
    #1;
    chk("arst_swrite", a_swrite, 1'b0);
    chk("arst_gnt", a_gnt, 4'b0000);
    a_req = 4'hF;
    #1 rst_n = 1'b1;
    step();
    chk("arst_restart_gnt", a_gnt, 4'b0001);
    chk("arst_swrite_again", a_swrite, 1'b1);

    // Fixed priority and protocol guard
    a_req = 4'h0; a_lock = 4'h0; a_read = 4'h0; a_write = 4'h0;
    b_req = 3'b110; b_read = 3'b100;
    step();
    chk("fp_gnt", b_gnt, 3'b010);
    chk("fp_guard_mwait", b_mwait, 3'b100);
    chk("fp_sread_only_owner", b_sread, 1'b0);
    chk("fp_saddr", b_saddr, 8'hC1);
    b_read = 3'b110;
    #1;
    chk("fp_sread_owner", b_sread, 1'b1);
    chk("fp_mwait2", b_mwait, 3'b100);
    b_req = 3'b111; b_read = 3'b000;
    step();
    chk("fp_gnt_low", b_gnt, 3'b001);

    // Unlimited lock keeps master 0 against competitors
    b_lock = 3'b001;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("fp_unlimited_lock", b_gnt, 3'b001);
    end
    b_lock = 3'b000;
    step();
    chk("fp_unlock_gnt", b_gnt, 3'b010);
    b_req = 3'b010;
    step();
    chk("fp_sole_owner_gnt", b_gnt, 3'b010);
    b_req = 3'b000;
    step();
    chk("fp_idle_gnt", b_gnt, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
